// File: rtl/prog_loader.sv
// prog_loader: fills the program RAM from an external byte stream while prog_mode
// is high. While a load is active it owns the shared bus and the mi/ri/ro strobes,
// and it holds the CPU halted.
module prog_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned VERIFY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              mi,
    output logic              ri,
    output logic              ro,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_ADDR,
        S_WAIT_BYTE,
        S_WRITE,
        S_VERIFY,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   cur_addr, cur_addr_n;
    logic [CNT_W-1:0]    remaining, remaining_n;
    logic [DATA_W-1:0]   data_reg, data_n;
    logic                err_n;
    logic [ADDR_W-1:0]   err_addr_n;

    logic                byte_ready_n;
    logic [DATA_W-1:0]   bus_out_n;
    logic                bus_oe_n;
    logic                mi_n;
    logic                ri_n;
    logic                ro_n;
    logic                busy_n;
    logic                done_n;

    // Next-state, datapath updates and output decode of the state being entered,
    // so every output is a flop that lines up with its state.
    always_comb begin
        state_n      = state;
        cur_addr_n   = cur_addr;
        remaining_n  = remaining;
        data_n       = data_reg;
        err_n        = err;
        err_addr_n   = err_addr;
        byte_ready_n = 1'b0;
        bus_out_n    = '0;
        bus_oe_n     = 1'b0;
        mi_n         = 1'b0;
        ri_n         = 1'b0;
        ro_n         = 1'b0;
        busy_n       = 1'b0;
        done_n       = 1'b0;

        if (state != S_IDLE && !prog_mode) begin
            // Losing prog_mode mid-load abandons it and flags the address reached.
            state_n    = S_IDLE;
            err_n      = 1'b1;
            err_addr_n = cur_addr;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && prog_mode) begin
                        cur_addr_n  = start_addr;
                        remaining_n = len;
                        err_n       = 1'b0;
                        err_addr_n  = '0;
                        state_n     = (len == '0) ? S_DONE : S_SET_ADDR;
                    end
                end
                S_SET_ADDR: state_n = S_WAIT_BYTE;
                S_WAIT_BYTE: begin
                    // byte_ready is always high in this state, so valid completes the handshake.
                    if (byte_valid) begin
                        data_n  = byte_in;
                        state_n = S_WRITE;
                    end
                end
                S_WRITE: state_n = (VERIFY != 0) ? S_VERIFY : S_NEXT;
                S_VERIFY: begin
                    // Only the first mismatch is recorded; the load carries on.
                    if (bus_in != data_reg && !err) begin
                        err_n      = 1'b1;
                        err_addr_n = cur_addr;
                    end
                    state_n = S_NEXT;
                end
                S_NEXT: begin
                    cur_addr_n  = cur_addr + ADDR_W'(1);
                    remaining_n = remaining - CNT_W'(1);
                    state_n     = (remaining_n == '0) ? S_DONE : S_SET_ADDR;
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end

        case (state_n)
            S_SET_ADDR: begin
                bus_oe_n  = 1'b1;
                bus_out_n = DATA_W'(cur_addr_n);
                mi_n      = 1'b1;
            end
            S_WAIT_BYTE: byte_ready_n = 1'b1;
            S_WRITE: begin
                bus_oe_n  = 1'b1;
                bus_out_n = data_n;
                ri_n      = 1'b1;
            end
            S_VERIFY: ro_n   = 1'b1;
            S_DONE:   done_n = !err_n;
            default: ;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            data_reg   <= '0;
            err        <= 1'b0;
            err_addr   <= '0;
            byte_ready <= 1'b0;
            bus_out    <= '0;
            bus_oe     <= 1'b0;
            mi         <= 1'b0;
            ri         <= 1'b0;
            ro         <= 1'b0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cur_addr   <= cur_addr_n;
            remaining  <= remaining_n;
            data_reg   <= data_n;
            err        <= err_n;
            err_addr   <= err_addr_n;
            byte_ready <= byte_ready_n;
            bus_out    <= bus_out_n;
            bus_oe     <= bus_oe_n;
            mi         <= mi_n;
            ri         <= ri_n;
            ro         <= ro_n;
            busy       <= busy_n;
            cpu_hold   <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Sequencer that fills the 16-byte RAM from an external byte stream while prog_mode is high.
- While active, it owns the shared 8-bit bus and drives the MAR-load (mi), RAM-write (ri) and RAM-out (ro) strobes in place of the instruction decoder.
- Each write can optionally be read back and compared.
- Sits between the chip IO pins and the bus/RAM. It holds the CPU halted and tri-states its own bus drive when idle.

Parameters:
- ADDR_W, 4, RAM address width; RAM depth is 2**ADDR_W.
- DATA_W, 8, bus and RAM word width.
- VERIFY, 1, when 1 every written byte is read back and compared; when 0 the VERIFY state is skipped.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- prog_mode  in  1  load permitted while high.
- start  in  1  one-cycle request to begin a load, sampled in IDLE only.
- start_addr  in  ADDR_W  first RAM address, sampled with start.
- len  in  ADDR_W+1  number of bytes to load (0..16), sampled with start.
- byte_in  in  DATA_W  incoming program byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- bus_in  in  DATA_W  current bus value, used for readback.
- bus_out  out  DATA_W  value the loader drives onto the bus.
- bus_oe  out  1  loader is driving the bus.
- mi  out  1  load the memory address register from bus[ADDR_W-1:0].
- ri  out  1  write the bus into RAM at the memory address register.
- ro  out  1  RAM drives the bus.
- cpu_hold  out  1  halt the CPU clock and decoder strobes.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky mismatch/abort flag, cleared by the next accepted start.
- err_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset (asynchronous, rst=0):
  - State forced to IDLE.
  - All outputs 0; bus_out=0; internal address and remaining-count registers 0.
  - Reset mid-operation abandons the load immediately and leaves no strobe high.
- States: IDLE, SET_ADDR, WAIT_BYTE, WRITE, VERIFY, NEXT, DONE. Every state other than WAIT_BYTE lasts exactly one cycle.
- IDLE:
  - On start=1 and prog_mode=1: latch start_addr into cur_addr and len into remaining; clear err and err_addr.
  - If len==0, go to DONE; otherwise go to SET_ADDR.
  - start with prog_mode=0 is ignored.
- SET_ADDR: bus_oe=1, bus_out={0, cur_addr}, mi=1 → WAIT_BYTE.
- WAIT_BYTE:
  - byte_ready=1.
  - On byte_valid & byte_ready, capture byte_in into data_reg → WRITE.
  - Otherwise stay.
- WRITE: bus_oe=1, bus_out=data_reg, ri=1 → VERIFY if VERIFY==1, else NEXT.
- VERIFY:
  - ro=1, bus_oe=0.
  - Compare bus_in to data_reg. On mismatch with err==0, set err=1 and err_addr=cur_addr. Only the first mismatch is recorded.
  - The load continues after a mismatch → NEXT.
- NEXT:
  - cur_addr increments modulo 2**ADDR_W (15 wraps to 0); remaining decrements.
  - If remaining becomes 0 → DONE, else → SET_ADDR.
- DONE: done=1 for one cycle if err==0 → IDLE.
- Minimum cycles per byte (byte_valid already high):
  - VERIFY=1: 4 cycles (SET_ADDR, WAIT_BYTE, WRITE, VERIFY) plus NEXT = 5.
  - VERIFY=0: 4 cycles.
- Exclusivity: mi, ri, ro are mutually exclusive; at most one is high in any cycle. bus_oe is never high together with ro.
- busy and cpu_hold are 1 in every state except IDLE.
- start while busy is ignored. byte_valid outside WAIT_BYTE is ignored, and the byte is not consumed.
- Abort: prog_mode falling in any non-IDLE state → next cycle IDLE, err=1, err_addr=cur_addr, no done pulse. Strobes drop in that same next cycle.
- All outputs are registered or decoded from state only; no combinational path from byte_valid to any strobe.

Test Plan:
- Load 3 bytes: start, start_addr=0, len=3, VERIFY=1, bytes 0x1E,0x2F,0xF0, RAM model echoes the write → mi/ri/ro pulses at addresses 0,1,2; done pulses once; err=0; RAM[0..2]=1E,2F,F0; 15 cycles from start to done when byte_valid is held high.
- Wrap-around: start_addr=14, len=4, bytes 0xA0..0xA3 → writes land at addresses 14,15,0,1; done=1; err=0.
- Readback fault: RAM model flips bit 0 on address 5; load start_addr=4, len=3 → err=1, err_addr=5; all three writes complete; no done pulse.
- Backpressure and zero length:
  - byte_valid held low for 10 cycles in WAIT_BYTE → byte_ready stays 1, no ri, state holds; ri follows one cycle after valid.
  - len=0 → DONE directly, done pulses, no strobe ever asserted.
- Abort and reset:
  - Drop prog_mode while in WRITE → next cycle IDLE, busy=0, err=1, no done.
  - Separately, assert rst=0 mid-VERIFY → all outputs 0 asynchronously; after rst=1 a fresh start loads normally.
